id_ex_stage: RTL and testbench

ID/EX pipeline register and EX-stage operand selector for the 5-stage pipeline. It latches decoded operands, control and the 2-bit forwarding codes (ALUSrcC/ALUSrcD) produced in ID by the forwarding unit. In EX it resolves those codes into the final ALU operands from the MEM-stage result, the Wr-stage write data, or a one-entry retired-write hold register. It also detects load-use hazards, stalls PC and IF/ID for exactly one cycle, and injects a bubble.

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
// A load in EX whose destination matches a source of the ID instruction stalls PC and IF/ID
// for one cycle while a bubble is loaded. The forwarding codes then resolve to the Wr-stage data.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_busA,
    input  logic [DATA_W-1:0] id_busB,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_RegWr,
    input  logic              id_MemtoReg,
    input  logic              id_ALUSrc,
    input  logic [1:0]        ALUSrcC,
    input  logic [1:0]        ALUSrcD,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_RegWr,
    output logic              stall,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_store,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_RegWr,
    output logic              ex_MemtoReg,
    output logic              ex_valid,
    output logic [4:0]        ex_Reg
);

    localparam int unsigned REG_W = 5;
    localparam logic [1:0]  SRC_REG  = 2'b00;
    localparam logic [1:0]  SRC_MEM  = 2'b01;
    localparam logic [1:0]  SRC_WR   = 2'b10;
    localparam logic [1:0]  SRC_HOLD = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] busA;
        logic [DATA_W-1:0] busB;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  dst;
        logic [CTRL_W-1:0] ctrl;
        logic              RegWr;
        logic              MemtoReg;
        logic              ALUSrc;
        logic [1:0]        codeC;
        logic [1:0]        codeD;
    } pr_t;

    pr_t               pr_q;
    pr_t               pr_d;
    logic [DATA_W-1:0] hold_q;
    logic              hz;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Load in EX feeding the ID instruction; rt is compared even for immediate-form consumers.
    assign hz = pr_q.valid & pr_q.MemtoReg & pr_q.RegWr & (pr_q.dst != REG_W'(0)) & id_valid
              & ((pr_q.dst == id_rs) | (pr_q.dst == id_rt));

    // A taken branch kills the ID instruction, so there is nothing left to stall for.
    assign stall = hz & ~flush;

    // Next pipeline-register contents: bubble on flush/hazard, else capture ID.
    always_comb begin
        pr_d = '0;
        if (!(flush || hz)) begin
            pr_d.valid    = id_valid;
            pr_d.busA     = id_busA;
            pr_d.busB     = id_busB;
            pr_d.imm      = id_imm;
            pr_d.dst      = id_dst;
            pr_d.ctrl     = id_ctrl;
            pr_d.RegWr    = id_RegWr;
            pr_d.MemtoReg = id_MemtoReg;
            pr_d.ALUSrc   = id_ALUSrc;
            pr_d.codeC    = ALUSrcC;
            pr_d.codeD    = ALUSrcD;
            if (!id_valid) begin
                pr_d.RegWr    = 1'b0;
                pr_d.MemtoReg = 1'b0;
                pr_d.ctrl     = '0;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q <= '0;
        end else begin
            pr_q <= pr_d;
        end
    end

    // One-entry hold of the most recently retired register write (code 11 source).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (wr_RegWr) begin
            hold_q <= wr_data;
        end
    end

    // Resolve forwarding codes into the rs/rt operand values.
    always_comb begin
        fwd_a = pr_q.busA;
        fwd_b = pr_q.busB;
        case (pr_q.codeC)
            SRC_REG:  fwd_a = pr_q.busA;
            SRC_MEM:  fwd_a = mem_result;
            SRC_WR:   fwd_a = wr_data;
            SRC_HOLD: fwd_a = hold_q;
            default:  fwd_a = pr_q.busA;
        endcase
        case (pr_q.codeD)
            SRC_REG:  fwd_b = pr_q.busB;
            SRC_MEM:  fwd_b = mem_result;
            SRC_WR:   fwd_b = wr_data;
            SRC_HOLD: fwd_b = hold_q;
            default:  fwd_b = pr_q.busB;
        endcase
    end

    assign ex_opA      = fwd_a;
    assign ex_store    = fwd_b;
    assign ex_opB      = pr_q.ALUSrc ? pr_q.imm : fwd_b;
    assign ex_ctrl     = pr_q.ctrl;
    assign ex_RegWr    = pr_q.RegWr;
    assign ex_MemtoReg = pr_q.MemtoReg;
    assign ex_valid    = pr_q.valid;
    assign ex_Reg      = pr_q.dst;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected values tagged with the cycle
// in which they must be observed; a negedge monitor pops and compares them.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 8;

    localparam int S_OPA = 0, S_OPB = 1, S_STORE = 2, S_STALL = 3, S_VALID = 4,
                   S_REGWR = 5, S_MTR = 6, S_REG = 7, S_CTRL = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [DATA_W-1:0] id_busA, id_busB, id_imm;
    logic [4:0]        id_rs, id_rt, id_dst;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_RegWr, id_MemtoReg, id_ALUSrc;
    logic [1:0]        ALUSrcC, ALUSrcD;
    logic              flush;
    logic [DATA_W-1:0] mem_result, wr_data;
    logic              wr_RegWr;
    logic              stall;
    logic [DATA_W-1:0] ex_opA, ex_opB, ex_store;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_RegWr, ex_MemtoReg, ex_valid;
    logic [4:0]        ex_Reg;

    id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_ctrl(id_ctrl),
        .id_RegWr(id_RegWr), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc),
        .ALUSrcC(ALUSrcC), .ALUSrcD(ALUSrcD), .flush(flush),
        .mem_result(mem_result), .wr_data(wr_data), .wr_RegWr(wr_RegWr),
        .stall(stall), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_store(ex_store),
        .ex_ctrl(ex_ctrl), .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg),
        .ex_valid(ex_valid), .ex_Reg(ex_Reg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_OPA:   return ex_opA;
            S_OPB:   return ex_opB;
            S_STORE: return ex_store;
            S_STALL: return 32'(stall);
            S_VALID: return 32'(ex_valid);
            S_REGWR: return 32'(ex_RegWr);
            S_MTR:   return 32'(ex_MemtoReg);
            S_REG:   return 32'(ex_Reg);
            S_CTRL:  return 32'(ex_ctrl);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle at mid-cycle.
    exp_t        m_e;
    string       m_n;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e   = exp_q.pop_front();
            m_n   = name_q.pop_front();
            m_act = actual(m_e.sel);
            checks++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d actual=0x%h expected=0x%h",
                         m_n, cyc, m_e.cyc, m_act, m_e.val);
            end
        end
    end

    task automatic push(input int dly, input int sel, input logic [31:0] val, input string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_busA = '0; id_busB = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_dst = '0; id_ctrl = '0;
        id_RegWr = 0; id_MemtoReg = 0; id_ALUSrc = 0;
        ALUSrcC = 2'b00; ALUSrcD = 2'b00; flush = 0;
        mem_result = '0; wr_data = '0; wr_RegWr = 0;
    endtask

    task automatic load_word(input logic [4:0] dst);
        clr();
        id_valid = 1; id_RegWr = 1; id_MemtoReg = 1; id_dst = dst;
        id_rs = 5'd1; id_rt = 5'd2;
    endtask

    initial begin
        rst_n = 0;
        clr();
        tick();
        tick();
        // reset state
        push(0, S_OPA, 0, "rst_opA");     push(0, S_OPB, 0, "rst_opB");
        push(0, S_STORE, 0, "rst_store"); push(0, S_STALL, 0, "rst_stall");
        push(0, S_VALID, 0, "rst_valid"); push(0, S_REGWR, 0, "rst_regwr");
        push(0, S_REG, 0, "rst_reg");     push(0, S_CTRL, 0, "rst_ctrl");

        // release and capture a real instruction
        tick();
        rst_n = 1;
        id_valid = 1; id_busA = 32'h11; id_RegWr = 1; id_dst = 5'd3; id_ctrl = 8'h5A;
        push(1, S_OPA, 32'h11, "rel_opA");   push(1, S_VALID, 1, "rel_valid");
        push(1, S_REG, 3, "rel_reg");        push(1, S_CTRL, 32'h5A, "rel_ctrl");
        push(1, S_REGWR, 1, "rel_regwr");
        tick();
        // PR stays loaded; assert reset mid-cycle, outputs clear without an edge
        tick();
        rst_n = 0;
        push(0, S_OPA, 0, "async_opA");   push(0, S_VALID, 0, "async_valid");
        push(0, S_REG, 0, "async_reg");   push(0, S_CTRL, 0, "async_ctrl");
        push(0, S_REGWR, 0, "async_regwr");
        tick();
        rst_n = 1;
        clr();

        // forwarding codes; prior retired write 0xC into hold
        tick();
        clr();
        wr_RegWr = 1; wr_data = 32'hC;
        id_valid = 1; id_busA = 32'h77; id_busB = 32'h22; id_imm = 32'h4;
        id_ALUSrc = 1; id_RegWr = 1; id_dst = 5'd7; ALUSrcC = 2'b01;
        tick();
        wr_RegWr = 0; wr_data = 32'hB; mem_result = 32'hA; ALUSrcC = 2'b10;
        push(0, S_OPA, 32'hA, "fwd01_opA"); push(0, S_OPB, 32'h4, "imm_opB");
        push(0, S_STORE, 32'h22, "d00_store");
        tick();
        ALUSrcC = 2'b11;
        push(0, S_OPA, 32'hB, "fwd10_opA");
        tick();
        ALUSrcD = 2'b11; id_ALUSrc = 0;
        push(0, S_OPA, 32'hC, "fwd11_opA");
        tick();
        push(0, S_OPB, 32'hC, "d11_opB"); push(0, S_STORE, 32'hC, "d11_store");
        clr();

        // load-use on rs: one stall, bubble, then forwarded load data
        tick();
        load_word(5'd5);
        tick();
        clr();
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd6; id_RegWr = 1; id_dst = 5'd8;
        push(0, S_STALL, 1, "lu_stall");
        tick();
        ALUSrcC = 2'b10;
        push(0, S_STALL, 0, "lu_stall_once"); push(0, S_VALID, 0, "lu_bub_valid");
        push(0, S_REGWR, 0, "lu_bub_regwr");  push(0, S_MTR, 0, "lu_bub_mtr");
        tick();
        clr();
        wr_data = 32'h1234;
        push(0, S_OPA, 32'h1234, "lu_opA"); push(0, S_VALID, 1, "lu_add_valid");
        push(0, S_REG, 8, "lu_add_reg");    push(0, S_STALL, 0, "lu_no_stall");

        // load to $0 never stalls
        tick();
        load_word(5'd0);
        tick();
        clr();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        push(0, S_STALL, 0, "r0_stall");

        // flush overrides hazard
        tick();
        load_word(5'd9);
        tick();
        clr();
        id_valid = 1; id_rs = 5'd9; id_RegWr = 1; id_dst = 5'd10; flush = 1;
        push(0, S_STALL, 0, "flush_stall");
        tick();
        load_word(5'd9);
        push(0, S_VALID, 0, "flush_bub_valid"); push(0, S_REGWR, 0, "flush_bub_regwr");
        tick();
        clr();
        id_valid = 0; id_rs = 5'd9; id_RegWr = 1; id_ctrl = 8'hFF; id_dst = 5'd4;
        push(0, S_STALL, 0, "inv_stall");
        tick();
        clr();
        push(0, S_VALID, 0, "inv_valid"); push(0, S_REGWR, 0, "inv_regwr");
        push(0, S_CTRL, 0, "inv_ctrl");

        // rt is compared even with immediate-select
        tick();
        load_word(5'd11);
        tick();
        clr();
        id_valid = 1; id_rt = 5'd11; id_ALUSrc = 1;
        push(0, S_STALL, 1, "rt_stall");
        tick();
        push(0, S_STALL, 0, "rt_stall_once");
        clr();

        // hold register keeps the last retired write
        tick();
        wr_RegWr = 1; wr_data = 32'h55;
        tick();
        clr();
        wr_data = 32'h99; id_valid = 1; ALUSrcC = 2'b11;
        tick();
        push(0, S_OPA, 32'h55, "hold_opA1");
        tick();
        push(0, S_OPA, 32'h55, "hold_opA2");
        tick();
        clr();

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
